// File: rtl/polilock_iniciador_if.sv
// Bundle of host-side and lock-core-side signals for the Polilock command initiator.
// master: the initiator (polilock_iniciador). slave: the host/lock-core side that drives requests and responses.
interface polilock_iniciador_if;
    // Host side
    logic       pedido;
    logic [1:0] pedido_funcao;
    logic       ocupado;
    logic       pronto;
    logic [1:0] resultado;
    // Lock-core side
    logic       iniciar;
    logic [1:0] funcao;
    logic       acertou;
    logic       errou;
    logic       db_bloqueado;

    modport master (
        input  pedido,
        input  pedido_funcao,
        input  acertou,
        input  errou,
        input  db_bloqueado,
        output iniciar,
        output funcao,
        output ocupado,
        output pronto,
        output resultado
    );

    modport slave (
        output pedido,
        output pedido_funcao,
        output acertou,
        output errou,
        output db_bloqueado,
        input  iniciar,
        input  funcao,
        input  ocupado,
        input  pronto,
        input  resultado
    );
endinterface

// File: rtl/polilock_iniciador.sv
// Polilock command initiator: takes a one-cycle host request and issues iniciar/funcao to the lock
// core. It then waits, with a timeout, for a rising edge on acertou/errou and reports one result
// code together with a one-cycle pronto pulse.
// Optional macro POLILOCK_PEDIDO_PENDENTE_EN: one-deep buffer for a request arriving while busy.
module polilock_iniciador #(
    parameter int unsigned INICIAR_CICLOS = 1,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input  logic                        clock,
    input  logic                        reset,
    polilock_iniciador_if.master        bus,
    output logic [3:0]                  db_estado
);

    localparam int unsigned EMITE_W   = 4;
    localparam int unsigned TIMEOUT_W = 16;
    localparam logic [EMITE_W-1:0]   EMITE_ULTIMO   = EMITE_W'(INICIAR_CICLOS - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ULTIMO = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

    localparam logic [1:0] RES_REJEITADO = 2'b00;
    localparam logic [1:0] RES_ACERTOU   = 2'b01;
    localparam logic [1:0] RES_ERROU     = 2'b10;
    localparam logic [1:0] RES_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        EMITE   = 3'd1,
        AGUARDA = 3'd2,
        CONCLUI = 3'd3,
        REJEITA = 3'd4
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [1:0]             funcao_q, funcao_d;
    logic                   iniciar_q, iniciar_d;
    logic                   pronto_q, pronto_d;
    logic [1:0]             resultado_q, resultado_d;
    logic [EMITE_W-1:0]     cnt_emite_q, cnt_emite_d;
    logic [TIMEOUT_W-1:0]   cnt_timeout_q, cnt_timeout_d;
    logic                   acertou_q, errou_q;
    logic                   acertou_sobe_c, errou_sobe_c;
    logic                   req_valido_c;
    logic [1:0]             req_funcao_c;

    // Rising-edge detection: a level held over from a previous command never counts as a response
    assign acertou_sobe_c = bus.acertou & ~acertou_q;
    assign errou_sobe_c   = bus.errou & ~errou_q;

`ifdef POLILOCK_PEDIDO_PENDENTE_EN
    logic       pend_valido_q, pend_valido_d;
    logic [1:0] pend_funcao_q, pend_funcao_d;

    // In OCIOSO a buffered request takes priority; a fresh pedido in that same cycle is dropped
    always_comb begin
        req_valido_c = bus.pedido;
        req_funcao_c = bus.pedido_funcao;
        if (pend_valido_q) begin
            req_valido_c = 1'b1;
            req_funcao_c = pend_funcao_q;
        end
    end

    // Pending buffer: fill on the first busy request, drain when issued from OCIOSO
    always_comb begin
        pend_valido_d = pend_valido_q;
        pend_funcao_d = pend_funcao_q;
        if (estado_q == OCIOSO) begin
            pend_valido_d = 1'b0;
        end else if (bus.pedido && !pend_valido_q) begin
            pend_valido_d = 1'b1;
            pend_funcao_d = bus.pedido_funcao;
        end
    end

    // Pending buffer register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valido_q <= 1'b0;
            pend_funcao_q <= 2'b00;
        end else begin
            pend_valido_q <= pend_valido_d;
            pend_funcao_q <= pend_funcao_d;
        end
    end
`else
    // Requests are only looked at in OCIOSO, so anything arriving while busy is dropped
    always_comb begin
        req_valido_c = bus.pedido;
        req_funcao_c = bus.pedido_funcao;
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        estado_d      = estado_q;
        funcao_d      = funcao_q;
        iniciar_d     = 1'b0;
        pronto_d      = 1'b0;
        resultado_d   = resultado_q;
        cnt_emite_d   = cnt_emite_q;
        cnt_timeout_d = cnt_timeout_q;

        unique case (estado_q)
            OCIOSO: begin
                if (req_valido_c) begin
                    funcao_d      = req_funcao_c;
                    cnt_emite_d   = '0;
                    cnt_timeout_d = '0;
                    if (bus.db_bloqueado) begin
                        estado_d    = REJEITA;
                        pronto_d    = 1'b1;
                        resultado_d = RES_REJEITADO;
                    end else begin
                        estado_d  = EMITE;
                        iniciar_d = 1'b1;
                    end
                end
            end
            EMITE: begin
                if (cnt_emite_q == EMITE_ULTIMO) begin
                    estado_d      = AGUARDA;
                    cnt_timeout_d = '0;
                end else begin
                    iniciar_d   = 1'b1;
                    cnt_emite_d = cnt_emite_q + EMITE_W'(1);
                end
            end
            AGUARDA: begin
                // errou has priority over acertou; any edge has priority over the timeout
                if (errou_sobe_c) begin
                    estado_d    = CONCLUI;
                    pronto_d    = 1'b1;
                    resultado_d = RES_ERROU;
                end else if (acertou_sobe_c) begin
                    estado_d    = CONCLUI;
                    pronto_d    = 1'b1;
                    resultado_d = RES_ACERTOU;
                end else if (cnt_timeout_q == TIMEOUT_ULTIMO) begin
                    estado_d    = CONCLUI;
                    pronto_d    = 1'b1;
                    resultado_d = RES_TIMEOUT;
                end else begin
                    cnt_timeout_d = cnt_timeout_q + TIMEOUT_W'(1);
                end
            end
            CONCLUI: estado_d = OCIOSO;
            REJEITA: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q      <= OCIOSO;
            funcao_q      <= 2'b00;
            iniciar_q     <= 1'b0;
            pronto_q      <= 1'b0;
            resultado_q   <= RES_REJEITADO;
            cnt_emite_q   <= '0;
            cnt_timeout_q <= '0;
        end else begin
            estado_q      <= estado_d;
            funcao_q      <= funcao_d;
            iniciar_q     <= iniciar_d;
            pronto_q      <= pronto_d;
            resultado_q   <= resultado_d;
            cnt_emite_q   <= cnt_emite_d;
            cnt_timeout_q <= cnt_timeout_d;
        end
    end

    // Previous response levels, updated every cycle regardless of state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
        end else begin
            acertou_q <= bus.acertou;
            errou_q   <= bus.errou;
        end
    end

    assign bus.iniciar   = iniciar_q;
    assign bus.funcao    = funcao_q;
    assign bus.pronto    = pronto_q;
    assign bus.resultado = resultado_q;
    assign bus.ocupado   = (estado_q != OCIOSO);
    assign db_estado     = 4'(estado_q);

endmodule

// File: tb/tb_polilock_iniciador.sv
// Directed bench for polilock_iniciador with INICIAR_CICLOS=1, TIMEOUT_CICLOS=8.
module tb_polilock_iniciador;

    logic       clock;
    logic       reset;
    logic [3:0] db_estado;
    int         checks;
    int         fails;

    polilock_iniciador_if bus();

    polilock_iniciador #(
        .INICIAR_CICLOS(1),
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.pedido = 1'b0; bus.pedido_funcao = 2'b00;
        bus.acertou = 1'b0; bus.errou = 1'b0; bus.db_bloqueado = 1'b0;
        #3;
        checks++; if ({bus.iniciar, bus.funcao, bus.ocupado, bus.pronto, bus.resultado, db_estado} !== 11'd0) begin
            fails++; $display("FAIL reset_outputs: got %b expected all zero",
                {bus.iniciar, bus.funcao, bus.ocupado, bus.pronto, bus.resultado, db_estado}); end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (db_estado !== 4'd0) begin fails++; $display("FAIL reset_idle_state: got %0d expected 0", db_estado); end
    endtask

    task automatic test_accept_success();
        bus.pedido_funcao = 2'b10; bus.pedido = 1'b1;
        tick();
        checks++; if (bus.iniciar !== 1'b1) begin fails++; $display("FAIL accept_iniciar_on: got %b expected 1", bus.iniciar); end
        checks++; if (bus.funcao !== 2'b10) begin fails++; $display("FAIL accept_funcao: got %b expected 10", bus.funcao); end
        checks++; if (db_estado !== 4'd1) begin fails++; $display("FAIL accept_estado_emite: got %0d expected 1", db_estado); end
        checks++; if (bus.ocupado !== 1'b1) begin fails++; $display("FAIL accept_ocupado: got %b expected 1", bus.ocupado); end
        bus.pedido = 1'b0; bus.pedido_funcao = 2'b00;
        tick();
        checks++; if (bus.iniciar !== 1'b0) begin fails++; $display("FAIL accept_iniciar_off: got %b expected 0", bus.iniciar); end
        checks++; if (db_estado !== 4'd2) begin fails++; $display("FAIL accept_estado_aguarda: got %0d expected 2", db_estado); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.iniciar, bus.pronto, bus.funcao} !== 4'b0010) begin
                fails++; $display("FAIL accept_wait_%0d: got %b expected 0010", i, {bus.iniciar, bus.pronto, bus.funcao}); end
        end
        bus.acertou = 1'b1;
        tick();
        checks++; if (bus.pronto !== 1'b1) begin fails++; $display("FAIL accept_pronto: got %b expected 1", bus.pronto); end
        checks++; if (bus.resultado !== 2'b01) begin fails++; $display("FAIL accept_resultado: got %b expected 01", bus.resultado); end
        checks++; if (db_estado !== 4'd3) begin fails++; $display("FAIL accept_estado_conclui: got %0d expected 3", db_estado); end
        bus.acertou = 1'b0;
        tick();
        checks++; if ({bus.pronto, bus.ocupado} !== 2'b00) begin
            fails++; $display("FAIL accept_done: got pronto,ocupado=%b expected 00", {bus.pronto, bus.ocupado}); end
        checks++; if (bus.resultado !== 2'b01) begin fails++; $display("FAIL accept_resultado_hold: got %b expected 01", bus.resultado); end
    endtask

    task automatic test_simultaneous();
        bus.pedido_funcao = 2'b01; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick();
        bus.acertou = 1'b1; bus.errou = 1'b1;
        tick();
        checks++; if ({bus.pronto, bus.resultado} !== 3'b110) begin
            fails++; $display("FAIL simultaneous_errou_wins: got pronto,resultado=%b expected 110", {bus.pronto, bus.resultado}); end
        bus.acertou = 1'b0; bus.errou = 1'b0;
        tick();
        checks++; if (bus.ocupado !== 1'b0) begin fails++; $display("FAIL simultaneous_idle: got %b expected 0", bus.ocupado); end
    endtask

    task automatic test_stale_level();
        bus.acertou = 1'b1;
        tick(); tick();
        bus.pedido_funcao = 2'b11; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.pronto, bus.ocupado} !== 2'b01) begin
                fails++; $display("FAIL stale_ignored_%0d: got pronto,ocupado=%b expected 01", i, {bus.pronto, bus.ocupado}); end
        end
        bus.acertou = 1'b0;
        tick();
        checks++; if (bus.pronto !== 1'b0) begin fails++; $display("FAIL stale_fall: got %b expected 0", bus.pronto); end
        bus.acertou = 1'b1;
        tick();
        checks++; if ({bus.pronto, bus.resultado} !== 3'b101) begin
            fails++; $display("FAIL stale_new_edge: got pronto,resultado=%b expected 101", {bus.pronto, bus.resultado}); end
        bus.acertou = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.pedido_funcao = 2'b10; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if ({bus.pronto, db_estado} !== 5'b0_0010) begin
                fails++; $display("FAIL timeout_early_%0d: got pronto,estado=%b expected 00010", i, {bus.pronto, db_estado}); end
        end
        tick();
        checks++; if ({bus.pronto, bus.resultado} !== 3'b111) begin
            fails++; $display("FAIL timeout_result: got pronto,resultado=%b expected 111", {bus.pronto, bus.resultado}); end
        tick();
        checks++; if ({bus.pronto, bus.ocupado} !== 2'b00) begin
            fails++; $display("FAIL timeout_idle: got pronto,ocupado=%b expected 00", {bus.pronto, bus.ocupado}); end
    endtask

    task automatic test_reset_mid();
        bus.pedido_funcao = 2'b01; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick(); tick();
        checks++; if ({bus.ocupado, bus.funcao, bus.resultado} !== 5'b1_01_11) begin
            fails++; $display("FAIL resetmid_before: got %b expected 10111", {bus.ocupado, bus.funcao, bus.resultado}); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.iniciar, bus.funcao, bus.ocupado, bus.pronto, bus.resultado, db_estado} !== 11'd0) begin
            fails++; $display("FAIL resetmid_async: got %b expected all zero",
                {bus.iniciar, bus.funcao, bus.ocupado, bus.pronto, bus.resultado, db_estado}); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.acertou = (i % 2 == 1);
            tick();
            checks++; if ({bus.pronto, bus.ocupado} !== 2'b00) begin
                fails++; $display("FAIL resetmid_no_pronto_%0d: got pronto,ocupado=%b expected 00", i, {bus.pronto, bus.ocupado}); end
        end
        bus.acertou = 1'b0;
        tick();
    endtask

    task automatic test_edge_on_timeout();
        bus.pedido_funcao = 2'b11; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (bus.pronto !== 1'b0) begin fails++; $display("FAIL edgeto_early_%0d: got %b expected 0", i, bus.pronto); end
        end
        bus.errou = 1'b1;
        tick();
        checks++; if ({bus.pronto, bus.resultado} !== 3'b110) begin
            fails++; $display("FAIL edgeto_edge_wins: got pronto,resultado=%b expected 110", {bus.pronto, bus.resultado}); end
        bus.errou = 1'b0;
        tick();
    endtask

    task automatic test_rejection();
        bus.db_bloqueado = 1'b1;
        bus.pedido_funcao = 2'b11; bus.pedido = 1'b1;
        tick();
        checks++; if ({bus.iniciar, bus.pronto, bus.resultado, bus.ocupado} !== 5'b0_1_00_1) begin
            fails++; $display("FAIL reject_outputs: got iniciar,pronto,resultado,ocupado=%b expected 01001",
                {bus.iniciar, bus.pronto, bus.resultado, bus.ocupado}); end
        checks++; if (db_estado !== 4'd4) begin fails++; $display("FAIL reject_estado: got %0d expected 4", db_estado); end
        bus.pedido = 1'b0; bus.db_bloqueado = 1'b0;
        tick();
        checks++; if ({bus.iniciar, bus.pronto, bus.ocupado, db_estado} !== 7'd0) begin
            fails++; $display("FAIL reject_back_idle: got %b expected 0000000", {bus.iniciar, bus.pronto, bus.ocupado, db_estado}); end
    endtask

    task automatic test_back_to_back_busy();
        bus.pedido_funcao = 2'b01; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0;
        tick();
        bus.pedido_funcao = 2'b10; bus.pedido = 1'b1;
        tick();
        checks++; if ({bus.iniciar, bus.ocupado, bus.funcao} !== 4'b0101) begin
            fails++; $display("FAIL busy_first_ignored: got %b expected 0101", {bus.iniciar, bus.ocupado, bus.funcao}); end
        bus.pedido_funcao = 2'b11; bus.pedido = 1'b1;
        tick();
        bus.pedido = 1'b0; bus.pedido_funcao = 2'b00; bus.acertou = 1'b1;
        tick();
        checks++; if ({bus.pronto, bus.resultado, bus.funcao} !== 5'b1_01_01) begin
            fails++; $display("FAIL busy_own_result: got %b expected 10101", {bus.pronto, bus.resultado, bus.funcao}); end
        bus.acertou = 1'b0;
        tick();
        checks++; if ({bus.ocupado, bus.pronto} !== 2'b00) begin
            fails++; $display("FAIL busy_return_idle: got %b expected 00", {bus.ocupado, bus.pronto}); end
        tick();
`ifdef POLILOCK_PEDIDO_PENDENTE_EN
        checks++; if ({bus.iniciar, bus.funcao, db_estado} !== 7'b1_10_0001) begin
            fails++; $display("FAIL busy_pending_issue: got %b expected 1100001", {bus.iniciar, bus.funcao, db_estado}); end
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if ({bus.pronto, bus.iniciar} !== 2'b00) begin
                fails++; $display("FAIL busy_pending_wait_%0d: got %b expected 00", i, {bus.pronto, bus.iniciar}); end
        end
        tick();
        checks++; if ({bus.pronto, bus.resultado} !== 3'b111) begin
            fails++; $display("FAIL busy_pending_timeout: got %b expected 111", {bus.pronto, bus.resultado}); end
        tick();
`else
        checks++; if ({bus.iniciar, bus.ocupado, bus.funcao} !== 4'b0001) begin
            fails++; $display("FAIL busy_dropped: got %b expected 0001", {bus.iniciar, bus.ocupado, bus.funcao}); end
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({bus.iniciar, bus.ocupado} !== 2'b00) begin
                fails++; $display("FAIL busy_second_dropped_%0d: got %b expected 00", i, {bus.iniciar, bus.ocupado}); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_accept_success();
        test_simultaneous();
        test_stale_level();
        test_timeout();
        test_reset_mid();
        test_edge_on_timeout();
        test_rejection();
        test_back_to_back_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/polilock_iniciador.md
Name: polilock_iniciador

Overview:
- Command initiator for the Polilock lock core: the requesting end of the iniciar/funcao -> acertou/errou protocol.
- Accepts a one-cycle request with a 2-bit function code from the host side (keypad/serial front end).
- Drives iniciar and funcao into the lock core, waits for the acertou/errou response with a timeout, and returns one result code with a one-cycle valid pulse.

Parameters:
- INICIAR_CICLOS, 1, width of the iniciar pulse in clocks (1..15).
- TIMEOUT_CICLOS, 1000, clocks allowed in AGUARDA before timeout (2..65535); timeout counter is 16 bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pedido  input  1  request strobe; sampled each clock.
- pedido_funcao  input  2  function code captured with pedido.
- acertou  input  1  success response from lock core.
- errou  input  1  failure response from lock core.
- db_bloqueado  input  1  lock core blocked indication.
- iniciar  output  1  start pulse to lock core.
- funcao  output  2  function code to lock core.
- ocupado  output  1  high whenever state != OCIOSO.
- pronto  output  1  one-cycle result-valid pulse.
- resultado  output  2  00 rejeitado (bloqueado), 01 acertou, 10 errou, 11 timeout.
- db_estado  output  4  state code for hex display.

Behaviour:
- Reset (reset=0, async) clears the following:
  - Outputs: iniciar=0, funcao=00, ocupado=0, pronto=0, resultado=00, db_estado=0.
  - Internals: state=OCIOSO, counters=0, edge registers=0.
  - Reset takes effect mid-operation as well; no result is reported for an aborted command.
- States and db_estado codes: OCIOSO=0, EMITE=1, AGUARDA=2, CONCLUI=3, REJEITA=4.
- OCIOSO:
  - pedido=1 captures pedido_funcao into the funcao register.
  - If db_bloqueado=1 in the same cycle -> REJEITA; otherwise -> EMITE.
  - pedido=0 -> stay.
- EMITE:
  - iniciar=1 for exactly INICIAR_CICLOS cycles. With pedido at edge N, iniciar is high on cycles N+1..N+INICIAR_CICLOS.
  - funcao is held stable from capture until return to OCIOSO.
  - Then -> AGUARDA with the timeout counter at 0.
- AGUARDA:
  - Responses are detected as rising edges: level & ~registered previous level. The edge registers update every cycle in all states, so a level still held from a prior operation is not accepted.
  - acertou edge -> CONCLUI with resultado=01.
  - errou edge -> CONCLUI with resultado=10.
  - Both edges in the same cycle -> errou wins (10).
  - Otherwise the counter increments. Counter reaching TIMEOUT_CICLOS-1 with no edge -> CONCLUI with resultado=11.
  - An edge in the same cycle as the timeout wins over the timeout.
- CONCLUI: pronto=1 for one cycle -> OCIOSO.
- REJEITA: resultado=00, pronto=1 for one cycle, iniciar is never asserted -> OCIOSO.
- Latency: response edge sampled at edge K -> pronto high during cycle K+1.
- resultado is registered and holds its value until the next pronto.
- pedido while ocupado=1 is ignored (see optional feature).
- No combinational path from inputs to outputs. All outputs are registered except ocupado and db_estado, which decode the state register.

Optional Feature:
- Macro: POLILOCK_PEDIDO_PENDENTE_EN.
- Without the macro: pedido while ocupado=1 is dropped.
- With the macro:
  - One-deep pending buffer. The first pedido (and its funcao) arriving while ocupado=1 is stored; later pedidos are dropped until the buffer drains.
  - On return to OCIOSO, a pending entry is issued in the next cycle exactly as a fresh pedido, including the db_bloqueado check at that cycle.
  - A pedido arriving in the same cycle as the issue is dropped.
  - Reset clears the buffer.
  - No port changes.

Test Plan:
- Accept/success: pedido=1, pedido_funcao=10, db_bloqueado=0, INICIAR_CICLOS=1. Required: iniciar high exactly one cycle; funcao=10 held. acertou rises 5 cycles later -> pronto pulse one cycle after the sampled edge, resultado=01, ocupado drops with pronto.
- Simultaneous response and stale level: acertou and errou rise in the same cycle -> resultado=10. Separately, hold acertou=1 from before the pedido -> no completion until acertou falls and rises again.
- Timeout: TIMEOUT_CICLOS=8, no response -> pronto exactly 8 cycles after entering AGUARDA, resultado=11. An edge arriving on the 8th cycle -> resultado from the edge, not 11.
- Rejection: db_bloqueado=1 with pedido -> iniciar never asserted; pronto next cycle; resultado=00; db_estado shows 4 then 0.
- Reset mid-operation: assert reset low during AGUARDA -> all outputs zero immediately (asynchronously); after release, no pronto until a new pedido.
- Busy requests: two pedidos during AGUARDA. Without the macro -> both ignored. With POLILOCK_PEDIDO_PENDENTE_EN -> first is issued one cycle after returning to OCIOSO with its own funcao; second dropped.
